fetch_queue: RTL and testbench

Instruction-fetch front end of the pipeline. Holds the fetch PC and issues word requests to instruction memory over a valid/ready handshake. Collects in-order responses into a small queue that presents `InstrD`/`PCD`/`PCPlus4D` to the decode stage, which feeds the immediate sign-extender and register file. Absorbs variable memory latency and decode stalls, and discards in-flight fetches on a branch/jump redirect.

---
 rtl/fetch_queue.sv | 150 +++++++++++++++
 tb/tb_fetch_queue.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end.
//
// Holds the fetch PC, issues word requests to instruction memory over a
// valid/ready handshake and collects the in-order responses into a small
// circular queue whose head feeds the decode stage.  A redirect flushes the
// queue and arranges for responses still in flight to be discarded.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   imem_req_valid    fetch request valid
//   imem_req_ready    memory accepts the request this cycle
//   imem_req_addr     word-aligned fetch address
//   imem_rsp_valid    in-order response valid (one per accepted request)
//   imem_rsp_data     instruction word
//   redirect_valid    branch/jump taken: flush and refetch
//   redirect_pc       new fetch PC (low two bits ignored)
//   StallD            decode cannot accept the head this cycle
//   ValidD            head slot holds a valid instruction
//   InstrD, PCD       head instruction and its PC
//   PCPlus4D          PCD + 4 (mod 2^32)
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        StallD,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]      pc;
  logic             run;
  logic [31:0]      slot_pc   [DEPTH];
  logic [31:0]      slot_data [DEPTH];
  logic [DEPTH-1:0] slot_filled;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    fill;
  logic [CW-1:0]    alloc;
  logic [CW-1:0]    drop;
  logic [CW-1:0]    filled_cnt;
  logic [CW-1:0]    in_use;
  logic [CW-1:0]    drop_flush;
  logic             accept;
  logic             rsp_keep;
  logic             rsp_drop;
  logic             dequeue;

  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + {{(CW-1){1'b0}}, slot_filled[i]};
    end
  end

  // alloc + drop never exceeds DEPTH, so both sums fit in CW bits.
  assign in_use = alloc + drop;

  // On a flush every allocated-but-unfilled slot still has a response in
  // flight; a response consumed this same cycle is no longer outstanding.
  assign drop_flush = drop + alloc - filled_cnt - {{(CW-1){1'b0}}, imem_rsp_valid};

  assign imem_req_valid = run && (in_use < DEPTH_C) && !redirect_valid;
  assign imem_req_addr  = pc;

  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && (drop == '0);
  assign rsp_drop = imem_rsp_valid && (drop != '0);

  assign ValidD   = slot_filled[head];
  assign InstrD   = slot_data[head];
  assign PCD      = slot_pc[head];
  assign PCPlus4D = slot_pc[head] + 32'd4;
  assign dequeue  = ValidD && !StallD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      run   <= 1'b0;
      head  <= '0;
      tail  <= '0;
      fill  <= '0;
      alloc <= '0;
      drop  <= '0;
      slot_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i]   <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        // Flush wins over accept/response/dequeue; slots are zeroed so no
        // stale PC can reach the decode outputs.
        pc    <= redirect_pc & 32'hFFFF_FFFC;
        head  <= '0;
        tail  <= '0;
        fill  <= '0;
        alloc <= '0;
        drop  <= drop_flush;
        slot_filled <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          slot_pc[i]   <= '0;
          slot_data[i] <= '0;
        end
      end else begin
        if (accept) begin
          slot_pc[tail]     <= pc;
          slot_filled[tail] <= 1'b0;
          tail              <= tail + PTR_ONE;
          pc                <= pc + 32'd4;
        end
        if (rsp_keep) begin
          slot_data[fill]   <= imem_rsp_data;
          slot_filled[fill] <= 1'b1;
          fill              <= fill + PTR_ONE;
        end
        if (rsp_drop) begin
          drop <= drop - CNT_ONE;
        end
        if (dequeue) begin
          slot_filled[head] <= 1'b0;
          head              <= head + PTR_ONE;
        end
        case ({accept, dequeue})
          2'b10:   alloc <= alloc + CNT_ONE;
          2'b01:   alloc <= alloc - CNT_ONE;
          default: alloc <= alloc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and random bench for fetch_queue with an in-order memory model
// and a transaction-level reference of the fetch/decode stream.
module tb_fetch_queue;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam int          DEPTH    = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        StallD;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;

  fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .StallD         (StallD),
    .ValidD         (ValidD),
    .InstrD         (InstrD),
    .PCD            (PCD),
    .PCPlus4D       (PCPlus4D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int cycle  = 0;
  int lat    = 1;
  int last_due = 0;
  int deq_total = 0;

  // memory pending responses
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  bit          mq_dead[$];
  // expected decode stream (allocated slots)
  logic [31:0] eq_addr[$];
  bit          eq_got[$];
  logic [31:0] pc_m;
  bit          run_m;
  logic [31:0] acc_log[$];
  logic [31:0] deq_log[$];

  logic        obs_reqv;
  logic [31:0] obs_addr;
  logic        obs_vld;
  logic [31:0] obs_pcd;
  logic [31:0] obs_instr;
  logic [31:0] obs_p4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
    end
  endtask

  function automatic int dead_cnt();
    int n = 0;
    foreach (mq_dead[i]) if (mq_dead[i]) n++;
    return n;
  endfunction

  // One clock cycle: check/observe at the falling edge, update the
  // reference, then drive the memory response for the next cycle.
  task automatic cyc();
    bit exp_req;
    bit exp_vld;
    bit acc;
    bit deq;
    bit live;
    bit found;
    int occ;
    int due;
    @(negedge clk);
    occ     = eq_addr.size() + dead_cnt();
    exp_req = run_m && (occ < DEPTH) && !redirect_valid;
    exp_vld = (eq_addr.size() > 0) && eq_got[0];
    obs_reqv  = imem_req_valid;
    obs_addr  = imem_req_addr;
    obs_vld   = ValidD;
    obs_pcd   = PCD;
    obs_instr = InstrD;
    obs_p4    = PCPlus4D;
    chk("req_valid", imem_req_valid, exp_req);
    if (imem_req_valid) chk("req_addr", imem_req_addr, pc_m);
    chk("ValidD", ValidD, exp_vld);
    if (ValidD && exp_vld) begin
      chk("PCD", PCD, eq_addr[0]);
      chk("InstrD", InstrD, eq_addr[0] + 32'h0000_A000);
      chk("PCPlus4D", PCPlus4D, eq_addr[0] + 32'd4);
    end
    chk("occupancy", occ <= DEPTH, 1);
    acc = imem_req_valid && imem_req_ready;
    deq = ValidD && !StallD;
    if (imem_rsp_valid && mq_addr.size() > 0) begin
      live = !mq_dead[0] && !redirect_valid;
      mq_addr.delete(0);
      mq_due.delete(0);
      mq_dead.delete(0);
      if (live) begin
        found = 1'b0;
        for (int i = 0; i < eq_got.size(); i++) begin
          if (!found && !eq_got[i]) begin
            eq_got[i] = 1'b1;
            found = 1'b1;
          end
        end
        chk("rsp_protocol", found, 1);
      end
    end
    if (redirect_valid) begin
      foreach (mq_dead[i]) mq_dead[i] = 1'b1;
      eq_addr.delete();
      eq_got.delete();
      pc_m = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (deq && eq_addr.size() > 0) begin
        deq_log.push_back(PCD);
        deq_total++;
        eq_addr.delete(0);
        eq_got.delete(0);
      end
      if (acc) begin
        due = cycle + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(due);
        mq_dead.push_back(1'b0);
        eq_addr.push_back(pc_m);
        eq_got.push_back(1'b0);
        acc_log.push_back(imem_req_addr);
        pc_m = pc_m + 32'd4;
      end
    end
    run_m = 1'b1;
    @(posedge clk);
    #1;
    cycle++;
    if (mq_addr.size() > 0 && mq_due[0] <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq_addr[0] + 32'h0000_A000;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  // Asynchronous reset pulse away from the clock edge; memory model and
  // reference are reset with the design.
  task automatic do_reset();
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_ValidD", ValidD, 0);
    chk("rst_InstrD", InstrD, 0);
    chk("rst_PCD", PCD, 0);
    chk("rst_PCPlus4D", PCPlus4D, 32'd4);
    mq_addr.delete(); mq_due.delete(); mq_dead.delete();
    eq_addr.delete(); eq_got.delete();
    acc_log.delete(); deq_log.delete();
    pc_m = RESET_PC;
    run_m = 1'b0;
    last_due = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    redirect_valid = 1'b0;
    StallD = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until_valid(input string tag, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      cyc();
      if (obs_vld) ok = 1'b1;
    end
    chk(tag, ok, 1);
  endtask

  initial begin
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    StallD         = 1'b0;
    pc_m  = RESET_PC;
    run_m = 1'b0;
    @(posedge clk);
    #1;

    // reset and start-up, 1-cycle memory
    do_reset();
    lat = 1;
    cyc(); chk("t1_req_c0", obs_reqv, 0);
    cyc(); chk("t1_req_c1", obs_reqv, 1); chk("t1_addr_c1", obs_addr, 32'h100);
    cyc(); chk("t1_vld_c2", obs_vld, 0);  chk("t1_addr_c2", obs_addr, 32'h104);
    cyc();
    chk("t1_vld_c3", obs_vld, 1);
    chk("t1_pcd_c3", obs_pcd, 32'h100);
    chk("t1_instr_c3", obs_instr, 32'hA100);
    chk("t1_p4_c3", obs_p4, 32'h104);
    chk("t1_full_c3", obs_reqv, 0);
    cyc(); chk("t1_vld_c4", obs_vld, 1); chk("t1_pcd_c4", obs_pcd, 32'h104);
    repeat (8) cyc();

    // stall and backpressure, entered through a mid-operation reset
    do_reset();
    StallD = 1'b1;
    repeat (5) cyc();
    chk("t2_acc_n", acc_log.size(), 2);
    chk("t2_full", obs_reqv, 0);
    chk("t2_vld", obs_vld, 1);
    chk("t2_head", obs_pcd, 32'h100);
    StallD = 1'b0;
    repeat (8) cyc();
    chk("t2_deq_n", deq_log.size() >= 3, 1);
    if (deq_log.size() >= 3) begin
      chk("t2_deq0", deq_log[0], 32'h100);
      chk("t2_deq1", deq_log[1], 32'h104);
      chk("t2_deq2", deq_log[2], 32'h108);
    end

    // redirect with two fetches in flight, 3-cycle memory
    do_reset();
    lat = 3;
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    cyc(); chk("t3_req_redir", obs_reqv, 0);
    redirect_valid = 1'b0;
    acc_log.delete(); deq_log.delete();
    cyc(); chk("t3_req_drop2", obs_reqv, 0);
    cyc(); chk("t3_req_drop1", obs_reqv, 1); chk("t3_addr", obs_addr, 32'h200);
    run_until_valid("t3_timeout", 10);
    chk("t3_pcd", obs_pcd, 32'h200);
    chk("t3_instr", obs_instr, 32'hA200);
    chk("t3_acc0", (acc_log.size() > 0) ? acc_log[0] : 32'hFFFF_FFFF, 32'h200);

    // redirect, response and dequeue in the same cycle
    do_reset();
    lat = 1;
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    cyc();
    chk("t4_vld_redir", obs_vld, 1);
    chk("t4_pcd_redir", obs_pcd, 32'h100);
    redirect_valid = 1'b0;
    deq_log.delete();
    cyc();
    chk("t4_empty", obs_vld, 0);
    chk("t4_req", obs_reqv, 1);
    chk("t4_addr", obs_addr, 32'h400);
    run_until_valid("t4_timeout", 10);
    chk("t4_pcd", obs_pcd, 32'h400);

    // wrap-around of the fetch PC
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    acc_log.delete(); deq_log.delete();
    run_until_valid("t5_timeout", 12);
    chk("t5_pcd", obs_pcd, 32'hFFFF_FFFC);
    chk("t5_instr", obs_instr, 32'h0000_9FFC);
    chk("t5_p4", obs_p4, 32'h0000_0000);
    repeat (4) cyc();
    chk("t5_acc_n", acc_log.size() >= 2, 1);
    if (acc_log.size() >= 2) begin
      chk("t5_acc0", acc_log[0], 32'hFFFF_FFFC);
      chk("t5_acc1", acc_log[1], 32'h0000_0000);
    end
    chk("t5_deq_n", deq_log.size() >= 2, 1);
    if (deq_log.size() >= 2) chk("t5_deq1", deq_log[1], 32'h0000_0000);

    // random stress against the reference
    deq_total = 0;
    for (int n = 0; n < 10000; n++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      lat            = $urandom_range(1, 4);
      StallD         = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom();
      cyc();
    end
    redirect_valid = 1'b0;
    chk("stress_progress", deq_total > 1000, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
